// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the packet-level FIFO write-port arbiter.
// The FIFO word is packed as {id, last, data}.
package cdc_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

  function automatic int fifo_word_width(input int data_w, input int id_w);
    return data_w + id_w + 1;
  endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// Combinational rotating-priority picker: the first set request after last_grant_i, wrapping.
// The request vector is doubled so that the wrap becomes a plain lowest-set-bit search.
module cdc_rr_pick
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic [ID_WIDTH-1:0] last_grant_i,
  output logic                found_o,
  output logic [ID_WIDTH-1:0] idx_o
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_mask;
  logic [2*NUM_REQ-1:0] w_masked;

  assign w_dbl = {req_i, req_i};

  // Window covers positions last_grant+1 .. last_grant+NUM_REQ, i.e. every requester once.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      w_mask[i] = (i > int'(last_grant_i)) && (i <= int'(last_grant_i) + NUM_REQ);
    end
  end

  assign w_masked = w_dbl & w_mask;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
      if (w_masked[i]) begin
        found_o = 1'b1;
        idx_o   = ID_WIDTH'(i % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/cdc_fifo_wr_arbiter.sv
// Packet-level round-robin arbiter for the write port of an async FIFO.
// A grant is held until the beat carrying last; each word is tagged with the requester ID.
module cdc_fifo_wr_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = $clog2(NUM_REQ),
  parameter int MAX_BEATS  = 256,
  parameter int FIFO_WIDTH = fifo_word_width(DATA_WIDTH, ID_WIDTH)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          fifo_wr_en_o,
  output logic [FIFO_WIDTH-1:0]         fifo_wr_data_o,
  input  logic                          fifo_full_i,
  input  logic                          fifo_almost_full_i,
  output logic [ID_WIDTH-1:0]           grant_id_o,
  output logic                          busy_o,
  output logic                          pkt_err_o
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  arb_state_e          r_state;
  logic [ID_WIDTH-1:0] r_grant_id;
  logic [ID_WIDTH-1:0] r_last_grant;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic                r_pkt_err;

  logic                w_found;
  logic [ID_WIDTH-1:0] w_pick;
  logic                w_lock;
  logic                w_beat;
  logic                w_last;

  cdc_rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req_i        (req_valid_i),
    .last_grant_i (r_last_grant),
    .found_o      (w_found),
    .idx_o        (w_pick)
  );

  assign w_lock = (r_state == ARB_LOCK);
  assign w_beat = w_lock & req_valid_i[r_grant_id] & ~fifo_full_i;
  assign w_last = req_last_i[r_grant_id];

  always_comb begin
    req_ready_o = '0;
    if (w_lock && !fifo_full_i) req_ready_o[r_grant_id] = 1'b1;
  end

  // Data is muxed from the granted requester unconditionally; the FIFO ignores it without wr_en.
  assign fifo_wr_en_o   = w_beat;
  assign fifo_wr_data_o = {r_grant_id, w_last, req_data_i[r_grant_id*DATA_WIDTH +: DATA_WIDTH]};

  assign grant_id_o = r_grant_id;
  assign busy_o     = w_lock;
  assign pkt_err_o  = r_pkt_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ARB_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= ID_WIDTH'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
      r_pkt_err    <= 1'b0;
    end else begin
      case (r_state)
        // almost_full only blocks opening a packet, never one already in flight.
        ARB_IDLE: begin
          if (w_found && !fifo_almost_full_i) begin
            r_grant_id <= w_pick;
            r_state    <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          if (w_beat) begin
            if (w_last) begin
              r_state      <= ARB_IDLE;
              r_last_grant <= r_grant_id;
              r_beat_cnt   <= '0;
            end else if (r_beat_cnt != CNT_W'(MAX_BEATS)) begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
              if (r_beat_cnt == CNT_W'(MAX_BEATS - 1)) r_pkt_err <= 1'b1;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_fifo_wr_arbiter.sv
// Directed bench for cdc_fifo_wr_arbiter with a cycle-level reference model and literal pins.
module tb_cdc_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int IW = 2;
  localparam int MB = 4;
  localparam int FW = DW + IW + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_last = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic           wr_en;
  logic [FW-1:0]  wr_data;
  logic           full = 1'b0;
  logic           afull = 1'b0;
  logic [IW-1:0]  gid;
  logic           busy;
  logic           perr;

  int n_checks = 0;
  int n_err = 0;
  logic [FW-1:0] got_q[$];

  // reference model state
  int m_busy, m_gid, m_lg, m_cnt, m_err;

  always #5 clk = ~clk;

  cdc_fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid),
    .req_last_i         (req_last),
    .req_data_i         (req_data),
    .req_ready_o        (req_ready),
    .fifo_wr_en_o       (wr_en),
    .fifo_wr_data_o     (wr_data),
    .fifo_full_i        (full),
    .fifo_almost_full_i (afull),
    .grant_id_o         (gid),
    .busy_o             (busy),
    .pkt_err_o          (perr)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model is evaluated mid-cycle: it checks the settled outputs, then advances one clock.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    logic          exp_wr;
    int            pick;
    logic          found;
    #2;
    if (!rst_n) begin
      m_busy = 0; m_gid = 0; m_lg = NR - 1; m_cnt = 0; m_err = 0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_grant", 32'(gid), 0);
      chk("rst_err", 32'(perr), 0);
    end else begin
      exp_rdy = '0;
      if (m_busy != 0 && !full) exp_rdy[m_gid] = 1'b1;
      exp_wr = (m_busy != 0) && req_valid[m_gid] && !full;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("grant_id", 32'(gid), 32'(m_gid));
      chk("ready", 32'(req_ready), 32'(exp_rdy));
      chk("wr_en", 32'(wr_en), 32'(exp_wr));
      chk("pkt_err", 32'(perr), 32'(m_err));
      if (exp_wr)
        chk("wr_data", 32'(wr_data), 32'({IW'(m_gid), req_last[m_gid], req_data[m_gid*DW +: DW]}));
      if (wr_en) got_q.push_back(wr_data);
      if (m_busy == 0) begin
        found = 1'b0;
        pick = 0;
        for (int k = 1; k <= NR; k++) begin
          if (!found && req_valid[(m_lg + k) % NR]) begin
            found = 1'b1;
            pick = (m_lg + k) % NR;
          end
        end
        if (found && !afull) begin
          m_busy = 1;
          m_gid = pick;
        end
      end else if (exp_wr) begin
        if (req_last[m_gid]) begin
          m_busy = 0; m_lg = m_gid; m_cnt = 0;
        end else if (m_cnt < MB) begin
          m_cnt++;
          if (m_cnt == MB) m_err = 1;
        end
      end
    end
  end

  task automatic set_beat(input int k, input logic [DW-1:0] d, input logic l);
    req_valid[k] = 1'b1;
    req_data[k*DW +: DW] = d;
    req_last[k] = l;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_last = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk("init_busy", 32'(busy), 0);
    chk("init_grant", 32'(gid), 0);
    chk("init_err", 32'(perr), 0);

    // Single 3-beat packet from req1
    @(negedge clk); got_q.delete();
    set_beat(1, 16'h00A1, 1'b0);
    @(negedge clk); // LOCK, beat A1
    @(negedge clk); set_beat(1, 16'h00A2, 1'b0);
    @(negedge clk); set_beat(1, 16'h00A3, 1'b1);
    @(negedge clk); clr_all();
    #3;
    chk("t1_busy_fall", 32'(busy), 0);
    chk("t1_count", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      chk("t1_w0", 32'(got_q[0]), 32'h200A1);
      chk("t1_w1", 32'(got_q[1]), 32'h200A2);
      chk("t1_w2", 32'(got_q[2]), 32'h300A3);
    end

    // Fairness from reset with 1-beat packets on all requesters
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1; got_q.delete();
    for (int k = 0; k < NR; k++) set_beat(k, 16'h0B00 + 16'(k), 1'b1);
    repeat (12) @(negedge clk);
    clr_all();
    #3;
    chk("t2_count", 32'(got_q.size()), 6);
    if (got_q.size() == 6) begin
      chk("t2_id0", 32'(got_q[0][FW-1 -: IW]), 0);
      chk("t2_id1", 32'(got_q[1][FW-1 -: IW]), 1);
      chk("t2_id2", 32'(got_q[2][FW-1 -: IW]), 2);
      chk("t2_id3", 32'(got_q[3][FW-1 -: IW]), 3);
      chk("t2_id4", 32'(got_q[4][FW-1 -: IW]), 0);
      chk("t2_id5", 32'(got_q[5][FW-1 -: IW]), 1);
      chk("t2_word3", 32'(got_q[3]), 32'h70B03);
    end

    // Full stall for 5 cycles mid-packet (req3)
    @(negedge clk); got_q.delete();
    set_beat(3, 16'h00C1, 1'b0);
    @(negedge clk);
    @(negedge clk); full = 1'b1; set_beat(3, 16'h00C2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("t3_ready_stall", 32'(req_ready), 0);
      chk("t3_wr_en_stall", 32'(wr_en), 0);
      @(negedge clk);
    end
    full = 1'b0;
    @(negedge clk); set_beat(3, 16'h00C3, 1'b1);
    @(negedge clk); clr_all();
    #3;
    chk("t3_count", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      chk("t3_w0", 32'(got_q[0]), 32'h600C1);
      chk("t3_w1", 32'(got_q[1]), 32'h600C2);
      chk("t3_w2", 32'(got_q[2]), 32'h700C3);
    end

    // almost_full blocks the grant but not an open packet (req2)
    @(negedge clk); got_q.delete();
    afull = 1'b1;
    set_beat(2, 16'h00D1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("t4_no_grant", 32'(busy), 0);
      @(negedge clk);
    end
    afull = 1'b0;
    @(negedge clk); afull = 1'b1;
    #3;
    chk("t4_busy", 32'(busy), 1);
    chk("t4_grant", 32'(gid), 2);
    @(negedge clk); set_beat(2, 16'h00D2, 1'b0);
    @(negedge clk); set_beat(2, 16'h00D3, 1'b1);
    @(negedge clk); clr_all(); afull = 1'b0;
    #3;
    chk("t4_count", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      chk("t4_w0", 32'(got_q[0]), 32'h400D1);
      chk("t4_w2", 32'(got_q[2]), 32'h500D3);
    end

    // Over-length packet from req0 with MAX_BEATS=4
    @(negedge clk); got_q.delete();
    set_beat(0, 16'h00E1, 1'b0);
    @(negedge clk);
    @(negedge clk); set_beat(0, 16'h00E2, 1'b0);
    @(negedge clk); set_beat(0, 16'h00E3, 1'b0);
    @(negedge clk); set_beat(0, 16'h00E4, 1'b0);
    #3;
    chk("t5_err_before", 32'(perr), 0);
    @(negedge clk); set_beat(0, 16'h00E5, 1'b0);
    #3;
    chk("t5_err_set", 32'(perr), 1);
    chk("t5_fifth_written", 32'(wr_en), 1);
    @(negedge clk); set_beat(0, 16'h00E6, 1'b0);
    #3;
    chk("t5_err_sticky", 32'(perr), 1);
    chk("t5_grant_kept", 32'(busy), 1);

    // Asynchronous reset between edges, mid-packet
    @(posedge clk); #2;
    chk("t5_count", 32'(got_q.size()), 6);
    if (got_q.size() == 6) begin
      chk("t5_w3", 32'(got_q[3]), 32'h000E4);
      chk("t5_w4", 32'(got_q[4]), 32'h000E5);
    end
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_wr_en", 32'(wr_en), 0);
    chk("t6_ready", 32'(req_ready), 0);
    chk("t6_grant", 32'(gid), 0);
    chk("t6_err", 32'(perr), 0);
    @(negedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < NR; k++) set_beat(k, 16'h0F00 + 16'(k), 1'b1);
    @(negedge clk);
    #3;
    chk("t6_first_grant", 32'(gid), 0);
    chk("t6_first_busy", 32'(busy), 1);
    @(negedge clk); clr_all();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
